// File: rtl/sm_sequencer.sv
// Frame sequencer for a Sherman-Morrison core: loads signature and matrix words, then gates one frame of pixels.
// Optional SM_SEQ_KEEP_CFG_EN lets START with KEEP_CFG skip both load phases and reuse the loaded configuration.
module sm_sequencer #(
    parameter int NUM_BANDS        = 16,
    parameter int CFG_DATA_WIDTH   = 32,
    parameter int PIXEL_DATA_WIDTH = 16,
    parameter int NPIX_WIDTH       = 24
) (
    input  logic                            CLK,
    input  logic                            RESET,
    input  logic                            START,
    input  logic                            KEEP_CFG,
    input  logic [NPIX_WIDTH-1:0]           NUM_PIXELS,
    input  logic [CFG_DATA_WIDTH-1:0]       S_AXIS_CFG_TDATA,
    input  logic                            S_AXIS_CFG_TVALID,
    output logic                            S_AXIS_CFG_TREADY,
    output logic                            SIG_WE,
    output logic                            MAT_WE,
    output logic [2*$clog2(NUM_BANDS)-1:0]  CFG_WADDR,
    output logic [CFG_DATA_WIDTH-1:0]       CFG_WDATA,
    output logic                            CORE_ENABLE,
    input  logic [PIXEL_DATA_WIDTH-1:0]     S_AXIS_PIX_TDATA,
    input  logic                            S_AXIS_PIX_TVALID,
    output logic                            S_AXIS_PIX_TREADY,
    output logic [PIXEL_DATA_WIDTH-1:0]     M_AXIS_PIX_TDATA,
    output logic                            M_AXIS_PIX_TVALID,
    output logic                            M_AXIS_PIX_TLAST,
    input  logic                            M_AXIS_PIX_TREADY,
    input  logic                            CORE_OUT_TVALID,
    input  logic                            CORE_OUT_TREADY,
    input  logic                            CORE_OUT_TLAST,
    output logic                            BUSY,
    output logic                            DONE
);

    localparam int ADDR_W = 2 * $clog2(NUM_BANDS);
    localparam logic [ADDR_W-1:0] SIG_LAST = ADDR_W'(NUM_BANDS - 1);
    localparam logic [ADDR_W-1:0] MAT_LAST = ADDR_W'(NUM_BANDS * NUM_BANDS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_SIG, S_LOAD_MAT, S_ARM, S_RUN, S_DRAIN, S_DONE
    } state_t;

    state_t                 state;
    logic [ADDR_W-1:0]      cfg_idx;
    logic [NPIX_WIDTH-1:0]  npix;
    logic [NPIX_WIDTH-1:0]  pix_cnt;

    logic cfg_hs, pix_gate, pix_last, pix_hs, core_last;

    assign cfg_hs    = S_AXIS_CFG_TVALID & S_AXIS_CFG_TREADY;
    assign pix_gate  = (state == S_RUN) && (pix_cnt < npix);
    assign pix_last  = (pix_cnt == npix - NPIX_WIDTH'(1));
    assign core_last = CORE_OUT_TVALID & CORE_OUT_TREADY & CORE_OUT_TLAST;

    // Pixel path stays combinational so the gate adds no bubble between upstream and core.
    assign S_AXIS_PIX_TREADY = pix_gate & M_AXIS_PIX_TREADY;
    assign M_AXIS_PIX_TVALID = pix_gate & S_AXIS_PIX_TVALID;
    assign M_AXIS_PIX_TLAST  = pix_gate & pix_last;
    assign M_AXIS_PIX_TDATA  = S_AXIS_PIX_TDATA;
    assign pix_hs            = M_AXIS_PIX_TVALID & M_AXIS_PIX_TREADY;

`ifndef SM_SEQ_KEEP_CFG_EN
    logic unused_keep_cfg;
    assign unused_keep_cfg = KEEP_CFG;
`endif

    // NOTE: every register, outputs included, is updated with <= so all of them see pre-edge values.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state             <= S_IDLE;
            cfg_idx           <= '0;
            npix              <= '0;
            pix_cnt           <= '0;
            S_AXIS_CFG_TREADY <= 1'b0;
            SIG_WE            <= 1'b0;
            MAT_WE            <= 1'b0;
            CFG_WADDR         <= '0;
            CFG_WDATA         <= '0;
            CORE_ENABLE       <= 1'b0;
            BUSY              <= 1'b0;
            DONE              <= 1'b0;
        end else begin
            SIG_WE <= 1'b0;
            MAT_WE <= 1'b0;
            DONE   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (START) begin
                        npix    <= NUM_PIXELS;
                        pix_cnt <= '0;
                        cfg_idx <= '0;
                        BUSY    <= 1'b1;
`ifdef SM_SEQ_KEEP_CFG_EN
                        if (KEEP_CFG) begin
                            state       <= S_ARM;
                            CORE_ENABLE <= 1'b1;
                        end else begin
                            state             <= S_LOAD_SIG;
                            S_AXIS_CFG_TREADY <= 1'b1;
                        end
`else
                        state             <= S_LOAD_SIG;
                        S_AXIS_CFG_TREADY <= 1'b1;
`endif
                    end
                end
                S_LOAD_SIG: begin
                    if (cfg_hs) begin
                        CFG_WDATA <= S_AXIS_CFG_TDATA;
                        CFG_WADDR <= cfg_idx;
                        SIG_WE    <= 1'b1;
                        if (cfg_idx == SIG_LAST) begin
                            cfg_idx <= '0;
                            state   <= S_LOAD_MAT;
                        end else begin
                            cfg_idx <= cfg_idx + 1'b1;
                        end
                    end
                end
                S_LOAD_MAT: begin
                    if (cfg_hs) begin
                        CFG_WDATA <= S_AXIS_CFG_TDATA;
                        CFG_WADDR <= cfg_idx;
                        MAT_WE    <= 1'b1;
                        cfg_idx   <= cfg_idx + 1'b1;
                        if (cfg_idx == MAT_LAST) begin
                            state             <= S_ARM;
                            S_AXIS_CFG_TREADY <= 1'b0;
                            CORE_ENABLE       <= 1'b1;
                        end
                    end
                end
                S_ARM: begin
                    if (npix == '0) begin
                        state       <= S_DONE;
                        DONE        <= 1'b1;
                        CORE_ENABLE <= 1'b0;
                    end else begin
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (pix_hs) begin
                        pix_cnt <= pix_cnt + 1'b1;
                        if (pix_last) state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (core_last) begin
                        state       <= S_DONE;
                        DONE        <= 1'b1;
                        CORE_ENABLE <= 1'b0;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    BUSY  <= 1'b0;
                end
                default: begin
                    state             <= S_IDLE;
                    BUSY              <= 1'b0;
                    CORE_ENABLE       <= 1'b0;
                    S_AXIS_CFG_TREADY <= 1'b0;
                end
            endcase
        end
    end

endmodule
